// File: rtl/key_tone_arbiter.sv
// key_tone_arbiter: shares one square-wave tone generator among debounced keys.
// The lowest-index valid key wins; notes change or stop only at the end of a full period.
module key_tone_arbiter #(
    parameter int C_CLK_FRQ     = 100_000_000,
    parameter int C_NUM_KEYS    = 8,
    parameter int C_HALF_PER_W  = 20,
    parameter int C_MIN_HOLD_MS = 20
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [C_NUM_KEYS-1:0]              keys,
    input  logic [C_NUM_KEYS*C_HALF_PER_W-1:0] half_per_tbl,
    output logic                               wave,
    output logic                               active,
    output logic [C_NUM_KEYS-1:0]              grant,
    output logic [$clog2(C_NUM_KEYS)-1:0]      key_idx,
    output logic                               note_start
);
    localparam int C_HOLD_CYC = C_CLK_FRQ / 1000 * C_MIN_HOLD_MS;
    localparam int C_HOLD_W   = (C_HOLD_CYC > 0) ? $clog2(C_HOLD_CYC + 1) : 1;
    localparam int C_IDX_W    = $clog2(C_NUM_KEYS);
    localparam int W          = C_HALF_PER_W;

    localparam logic [C_HOLD_W-1:0]   C_HOLD_MAX  = C_HOLD_W'(C_HOLD_CYC);
    localparam logic [C_HOLD_W-1:0]   C_HOLD_LAST = (C_HOLD_CYC > 0) ? C_HOLD_W'(C_HOLD_CYC - 1)
                                                                     : {C_HOLD_W{1'b0}};
    localparam logic [C_HOLD_W-1:0]   C_HOLD_ONE  = {{(C_HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]          C_HP_ONE    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [C_NUM_KEYS-1:0] C_GNT_ONE   = {{(C_NUM_KEYS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           hp_q, hp_d;
    logic [W-1:0]           phase_q, phase_d;
    logic [C_HOLD_W-1:0]    hold_q, hold_d;
    logic                   wave_q, wave_d;
    logic                   active_q, active_d;
    logic [C_NUM_KEYS-1:0]  grant_q, grant_d;
    logic [C_IDX_W-1:0]     key_idx_q, key_idx_d;
    logic                   note_start_q, note_start_d;

    logic [C_NUM_KEYS-1:0]  valid_s;
    logic                   any_valid_s;
    logic [C_IDX_W-1:0]     win_idx_s;
    logic [W-1:0]           win_hp_s;
    logic                   phase_end_s;
    logic                   boundary_s;
    logic                   do_grant_s;

    // Valid keys and lowest-index winner; scanning downwards leaves the lowest index last.
    always_comb begin
        valid_s     = {C_NUM_KEYS{1'b0}};
        any_valid_s = 1'b0;
        win_idx_s   = {C_IDX_W{1'b0}};
        for (int i = C_NUM_KEYS - 1; i >= 0; i--) begin
            valid_s[i]  = keys[i] && (half_per_tbl[i*W +: W] != {W{1'b0}});
            win_idx_s   = valid_s[i] ? C_IDX_W'(i) : win_idx_s;
            any_valid_s = any_valid_s | valid_s[i];
        end
        win_hp_s = half_per_tbl[int'(win_idx_s)*W +: W];
    end

    assign phase_end_s = (phase_q == (hp_q - C_HP_ONE));
    assign boundary_s  = ~wave_q & phase_end_s;

    // Next-state, tone stepping and grant decisions.
    always_comb begin
        state_d      = state_q;
        hp_d         = hp_q;
        phase_d      = phase_end_s ? {W{1'b0}} : (phase_q + C_HP_ONE);
        wave_d       = phase_end_s ? ~wave_q : wave_q;
        hold_d       = hold_q;
        active_d     = active_q;
        grant_d      = grant_q;
        key_idx_d    = key_idx_q;
        note_start_d = 1'b0;
        do_grant_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                phase_d = {W{1'b0}};
                wave_d  = 1'b0;
                if (any_valid_s) begin
                    do_grant_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                hold_d = (hold_q == C_HOLD_MAX) ? hold_q : (hold_q + C_HOLD_ONE);
                if (hold_q == C_HOLD_LAST) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_PLAY: begin
                if (boundary_s && !any_valid_s) begin
                    state_d   = ST_IDLE;
                    phase_d   = {W{1'b0}};
                    wave_d    = 1'b0;
                    active_d  = 1'b0;
                    grant_d   = {C_NUM_KEYS{1'b0}};
                    key_idx_d = {C_IDX_W{1'b0}};
                end else if (boundary_s && (win_idx_s != key_idx_q)) begin
                    do_grant_s = 1'b1;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                phase_d   = {W{1'b0}};
                wave_d    = 1'b0;
                active_d  = 1'b0;
                grant_d   = {C_NUM_KEYS{1'b0}};
                key_idx_d = {C_IDX_W{1'b0}};
            end
        endcase

        // A new grant restarts the tone high with fresh counters and a latched half period.
        if (do_grant_s) begin
            state_d      = (C_HOLD_CYC == 0) ? ST_PLAY : ST_HOLD;
            hp_d         = win_hp_s;
            phase_d      = {W{1'b0}};
            hold_d       = {C_HOLD_W{1'b0}};
            wave_d       = 1'b1;
            active_d     = 1'b1;
            grant_d      = C_GNT_ONE << win_idx_s;
            key_idx_d    = win_idx_s;
            note_start_d = 1'b1;
        end else begin
            note_start_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hp_q         <= {W{1'b0}};
            phase_q      <= {W{1'b0}};
            hold_q       <= {C_HOLD_W{1'b0}};
            wave_q       <= 1'b0;
            active_q     <= 1'b0;
            grant_q      <= {C_NUM_KEYS{1'b0}};
            key_idx_q    <= {C_IDX_W{1'b0}};
            note_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hp_q         <= hp_d;
            phase_q      <= phase_d;
            hold_q       <= hold_d;
            wave_q       <= wave_d;
            active_q     <= active_d;
            grant_q      <= grant_d;
            key_idx_q    <= key_idx_d;
            note_start_q <= note_start_d;
        end
    end

    assign wave       = wave_q;
    assign active     = active_q;
    assign grant      = grant_q;
    assign key_idx    = key_idx_q;
    assign note_start = note_start_q;

endmodule

// File: tb/tb_key_tone_arbiter.sv
// Bench for key_tone_arbiter: table vectors, directed timing sequences and a
// randomized run against a time-based reference model of the arbiter.
module tb_key_tone_arbiter;
    localparam int N      = 8;
    localparam int W      = 8;
    localparam int C_HOLD = 1000;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   keys_r = '0;
    logic [N*W-1:0] tbl_r = '0;
    logic           wave, active, note_start;
    logic [N-1:0]   grant;
    logic [2:0]     key_idx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    bit m_active = 1'b0;
    bit m_start  = 1'b0;
    int m_key = 0;
    int m_hp  = 1;
    int m_tg  = 0;

    key_tone_arbiter #(
        .C_CLK_FRQ    (1_000_000),
        .C_NUM_KEYS   (N),
        .C_HALF_PER_W (W),
        .C_MIN_HOLD_MS(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .keys        (keys_r),
        .half_per_tbl(tbl_r),
        .wave        (wave),
        .active      (active),
        .grant       (grant),
        .key_idx     (key_idx),
        .note_start  (note_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  keys;
        logic [63:0] tbl;
        logic        exp_active;
        logic [7:0]  exp_grant;
        logic [2:0]  exp_idx;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a note started at edge tg may change only at edges tg+2*hp*k
    // that lie strictly beyond the hold time; wave is high in even half-periods.
    task automatic model_edge();
        int  w;
        bit  any;
        int  el;
        w   = 0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (keys_r[i] && tbl_r[i*W +: W] != 8'd0) begin
                w   = i;
                any = 1'b1;
            end
        end
        m_start = 1'b0;
        if (!m_active) begin
            if (any) begin
                m_active = 1'b1; m_key = w; m_hp = int'(tbl_r[w*W +: W]); m_tg = cyc; m_start = 1'b1;
            end
        end else begin
            el = cyc - m_tg;
            if ((el % (2 * m_hp)) == 0 && el > C_HOLD) begin
                if (!any) begin
                    m_active = 1'b0;
                end else if (w != m_key) begin
                    m_key = w; m_hp = int'(tbl_r[w*W +: W]); m_tg = cyc; m_start = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        logic [13:0] act_v, exp_v;
        logic        e_wave;
        logic [7:0]  e_grant;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        e_wave  = m_active && ((((cyc - m_tg) / m_hp) % 2) == 0);
        e_grant = m_active ? (8'd1 << m_key) : 8'd0;
        act_v = {wave, active, grant, key_idx, note_start};
        exp_v = {e_wave, m_active, e_grant, m_active ? 3'(m_key) : 3'd0, m_start};
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL model cyc=%0d: got wave=%b active=%b grant=%h key_idx=%0d note_start=%b expected wave=%b active=%b grant=%h key_idx=%0d note_start=%b",
                     cyc, wave, active, grant, key_idx, note_start,
                     e_wave, m_active, e_grant, m_active ? m_key : 0, m_start);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_async_clear", 32'({wave, active, grant, key_idx, note_start}), 32'd0);
        #1;
        rst = 1'b0;
        m_active = 1'b0;
        m_start  = 1'b0;
    endtask

    initial begin
        int g;
        bit found;
        int ns_cnt;
        int tog_cnt;
        logic prev_w;

        vecs[0] = '{8'h04, 64'h0000_0000_0005_0000, 1'b1, 8'h04, 3'd2};
        vecs[1] = '{8'h09, 64'h0000_0000_0700_0000, 1'b1, 8'h08, 3'd3};
        vecs[2] = '{8'h00, 64'h0101_0101_0101_0101, 1'b0, 8'h00, 3'd0};
        vecs[3] = '{8'hFF, 64'h0909_0909_0909_0909, 1'b1, 8'h01, 3'd0};
        vecs[4] = '{8'h80, 64'h0900_0000_0000_0000, 1'b1, 8'h80, 3'd7};
        vecs[5] = '{8'hF0, 64'h0203_0000_0000_0000, 1'b1, 8'h40, 3'd6};
        vecs[6] = '{8'h10, 64'h0000_0001_0000_0000, 1'b1, 8'h10, 3'd4};
        vecs[7] = '{8'h01, 64'h0000_0000_0000_0000, 1'b0, 8'h00, 3'd0};
        vecs[8] = '{8'h22, 64'h0000_0400_0000_0300, 1'b1, 8'h02, 3'd1};

        #1;
        do_reset();

        for (int v = 0; v < 9; v++) begin
            do_reset();
            tbl_r  = vecs[v].tbl;
            keys_r = vecs[v].keys;
            step();
            chk($sformatf("vec%0d", v),
                32'({active, grant, key_idx, note_start, wave}),
                32'({vecs[v].exp_active, vecs[v].exp_grant, vecs[v].exp_idx,
                     vecs[v].exp_active, vecs[v].exp_active}));
            run(3);
        end

        // Key 2 plays, is released during the hold, stops at the first boundary past the hold.
        do_reset();
        tbl_r = 64'h0000_0000_0005_0000; keys_r = 8'h04;
        step();
        g = cyc;
        run(299);
        keys_r = 8'h00;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step();
            if (!active) found = 1'b1;
        end
        chk("stop_time", 32'(cyc - g), 32'd1010);
        chk("stop_grant", 32'(grant), 32'd0);

        // Key 5 plays; higher-priority key 1 arrives during the hold, takes over after it.
        do_reset();
        tbl_r = 64'h0000_0400_0000_0300; keys_r = 8'h20;
        step();
        g = cyc;
        run(199);
        keys_r = 8'h22;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step();
            if (note_start) found = 1'b1;
        end
        chk("regrant_time", 32'(cyc - g), 32'd1008);
        chk("regrant_grant", 32'(grant), 32'h02);
        run(40);

        // Reset mid-note, then stay idle without valid keys.
        do_reset();
        keys_r = 8'h00;
        run(20);
        chk("idle_after_rst", 32'(active), 32'd0);
        keys_r = 8'h02;
        step();
        chk("grant_after_rst", 32'(grant), 32'h02);

        // Half period of 1: wave toggles every cycle, one note_start only.
        do_reset();
        tbl_r = 64'h0000_0001_0000_0000; keys_r = 8'h10;
        step();
        ns_cnt  = note_start ? 1 : 0;
        tog_cnt = 0;
        prev_w  = wave;
        for (int i = 0; i < 1199; i++) begin
            step();
            if (note_start) ns_cnt++;
            if (wave != prev_w) tog_cnt++;
            prev_w = wave;
        end
        chk("hp1_note_starts", 32'(ns_cnt), 32'd1);
        chk("hp1_toggles", 32'(tog_cnt), 32'd1199);

        // Randomized keys and table contents against the reference model.
        do_reset();
        for (int i = 0; i < N; i++) tbl_r[i*W +: W] = 8'($urandom_range(0, 6));
        keys_r = 8'($urandom);
        for (int c = 0; c < 30000; c++) begin
            if ($urandom_range(0, 149) == 0) keys_r = 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                for (int i = 0; i < N; i++) tbl_r[i*W +: W] = 8'($urandom_range(0, 6));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
